z_word_framer: RTL and testbench

Downstream consumer of the sequential circuit's serial output `z`. It samples `z` on qualified clock edges and packs WIDTH consecutive samples into a parallel word. Each word carries its population count. Completed words go out through a one-entry output register with a valid/ready handshake. Words that arrive while the output register is still occupied are dropped, and a sticky overflow flag records the loss.

---
 rtl/z_word_framer_pkg.sv | 16 +
 rtl/z_word_framer_if.sv | 29 ++
 rtl/z_word_framer_collector.sv | 42 ++++
 rtl/z_word_framer.sv | 135 +++++++++++++
 tb/tb_z_word_framer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/z_word_framer_pkg.sv
// Shared types, defaults and width helpers for the serial word framer.
package z_framer_pkg;

    localparam int DEF_WIDTH = 8;

    // Width of a counter able to hold the values 0..w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/z_word_framer_if.sv
// Word output channel: completed word, its ones count, and valid/ready handshake.
interface z_word_framer_if
    import z_framer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] word;
    logic [CW-1:0]    ones;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output word,
        output ones,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word,
        input  ones,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/z_word_framer_collector.sv
// Serial-to-parallel collector: shifts qualified z samples MSB-first and
// strobes done on the edge that samples the last bit of a word.
module z_shift_collector
    import z_framer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             z_en,
    output logic             done,
    output logic [WIDTH-1:0] word_out
);

    localparam int            BW      = $clog2(WIDTH);
    localparam logic [BW-1:0] BC_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BC_ONE  = BW'(1);

    logic [WIDTH-1:0] sh_r;
    logic [BW-1:0]    bc_r;

    // Shift in each qualified sample and track its position within the word
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_r <= '0;
            bc_r <= '0;
        end else if (z_en) begin
            sh_r <= {sh_r[WIDTH-2:0], z};
            if (bc_r == BC_LAST) begin
                bc_r <= '0;
            end else begin
                bc_r <= bc_r + BC_ONE;
            end
        end
    end

    // The completed word includes the bit being sampled on this edge.
    assign done     = z_en && (bc_r == BC_LAST);
    assign word_out = {sh_r[WIDTH-2:0], z};

endmodule

// File: rtl/z_word_framer.sv
// Packs WIDTH serial z samples into words, attaches a popcount, and hands
// them out through a one-entry register; words arriving while it is still
// occupied are dropped and flagged in a sticky overflow bit.
module z_word_framer
    import z_framer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              z,
    input  logic              z_en,
    input  logic              clr_ovf,
    output logic              overflow,
    z_word_framer_if.master   wout
);

    localparam int CW = cnt_w(WIDTH);

    out_state_t       state_r;
    out_state_t       next_state_s;
    logic             done_s;
    logic             take_s;
    logic             load_s;
    logic             drop_s;
    logic [WIDTH-1:0] cword_s;
    logic [WIDTH-1:0] word_r;
    logic [CW-1:0]    ones_r;
    logic             ovf_r;

    // Number of set bits in a word; result spans 0..WIDTH without wrapping.
    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    z_shift_collector #(
        .WIDTH (WIDTH)
    ) u_collector (
        .clk      (clk),
        .reset    (reset),
        .z        (z),
        .z_en     (z_en),
        .done     (done_s),
        .word_out (cword_s)
    );

    // word_ready only counts while a word is actually held.
    assign take_s = (state_r == OUT_FULL) && wout.word_ready;

    // Output stage state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= OUT_EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Output stage next-state: fill on done, drain on take unless refilled
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            OUT_EMPTY: begin
                if (done_s) begin
                    next_state_s = OUT_FULL;
                end else begin
                    next_state_s = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (take_s && !done_s) begin
                    next_state_s = OUT_EMPTY;
                end else begin
                    next_state_s = OUT_FULL;
                end
            end
            default: begin
                next_state_s = OUT_EMPTY;
            end
        endcase
    end

    // Output stage actions: load a fresh word when there is room, drop otherwise
    always_comb begin
        load_s = 1'b0;
        drop_s = 1'b0;
        case (state_r)
            OUT_EMPTY: begin
                load_s = done_s;
                drop_s = 1'b0;
            end
            OUT_FULL: begin
                load_s = done_s && take_s;
                drop_s = done_s && !take_s;
            end
            default: begin
                load_s = 1'b0;
                drop_s = 1'b0;
            end
        endcase
    end

    // Word and popcount register; changes only on load edges
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r <= '0;
            ones_r <= '0;
        end else if (load_s) begin
            word_r <= cword_s;
            ones_r <= popcount(cword_s);
        end
    end

    // Sticky overflow flag; a drop beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (clr_ovf) begin
            ovf_r <= 1'b0;
        end
    end

    assign wout.word       = word_r;
    assign wout.ones       = ones_r;
    assign wout.word_valid = (state_r == OUT_FULL);
    assign overflow        = ovf_r;

endmodule

// File: tb/tb_z_word_framer.sv
// Self-checking bench for z_word_framer (WIDTH=8): directed scenarios,
// a table of single-word vectors, and randomized traffic against a
// queue-based reference model.
module tb_z_word_framer;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic z       = 1'b0;
    logic z_en    = 1'b0;
    logic clr_ovf = 1'b0;
    logic rdy     = 1'b0;
    logic overflow;

    z_word_framer_if #(.WIDTH(W)) wif ();
    assign wif.word_ready = rdy;

    z_word_framer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .z        (z),
        .z_en     (z_en),
        .clr_ovf  (clr_ovf),
        .overflow (overflow),
        .wout     (wif)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    bit         mq[$];
    logic [7:0] m_word  = 8'h00;
    int         m_ones  = 0;
    bit         m_valid = 1'b0;
    bit         m_ovf   = 1'b0;

    // Capture of words seen while valid
    bit         cap_on = 1'b0;
    logic [7:0] seen_w[$];
    int         seen_o[$];

    typedef struct {
        logic [7:0] din;
        int         exp_ones;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_edge();
        bit         done;
        bit         take;
        bit         drop;
        logic [7:0] nw;
        if (reset) begin
            mq.delete();
            m_word  = 8'h00;
            m_ones  = 0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            done = 1'b0;
            nw   = 8'h00;
            take = m_valid && rdy;
            if (z_en) begin
                mq.push_back(z);
                if (mq.size() == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) nw[W-1-i] = mq[i];
                    mq.delete();
                end
            end
            drop = done && m_valid && !take;
            if (done && (!m_valid || take)) begin
                m_word  = nw;
                m_ones  = $countones(nw);
                m_valid = 1'b1;
            end else if (take) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    endtask

    task automatic step(input logic zi, input logic eni, input logic rdyi,
                        input logic clri, input logic rsti);
        @(negedge clk);
        z       = zi;
        z_en    = eni;
        rdy     = rdyi;
        clr_ovf = clri;
        reset   = rsti;
        @(posedge clk);
        model_edge();
        #1;
        chk("word",     32'(wif.word),       32'(m_word));
        chk("ones",     32'(wif.ones),       32'(m_ones));
        chk("valid",    32'(wif.word_valid), 32'(m_valid));
        chk("overflow", 32'(overflow),       32'(m_ovf));
        if (cap_on && wif.word_valid) begin
            seen_w.push_back(wif.word);
            seen_o.push_back(int'(wif.ones));
        end
    endtask

    task automatic idle(input logic rdyi);
        step(1'b0, 1'b0, rdyi, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic feed_byte(input logic [7:0] b, input logic rdyi);
        for (int i = W - 1; i >= 0; i--) step(b[i], 1'b1, rdyi, 1'b0, 1'b0);
    endtask

    task automatic feed_byte_gapped(input logic [7:0] b, input logic rdyi);
        int gap;
        for (int i = W - 1; i >= 0; i--) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) idle(rdyi);
            step(b[i], 1'b1, rdyi, 1'b0, 1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{8'h00, 0};
        tbl[1] = '{8'hFF, 8};
        tbl[2] = '{8'h80, 1};
        tbl[3] = '{8'h01, 1};
        tbl[4] = '{8'hAA, 4};
        tbl[5] = '{8'h3C, 4};
        tbl[6] = '{8'h7E, 6};
        tbl[7] = '{8'hE7, 6};

        // Reset then idle
        do_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            chk("idle_valid", 32'(wif.word_valid), 32'd0);
            chk("idle_word",  32'(wif.word),       32'd0);
            chk("idle_ones",  32'(wif.ones),       32'd0);
            chk("idle_ovf",   32'(overflow),       32'd0);
        end

        // Single word, valid for exactly one cycle
        for (int i = 0; i < 7; i++) begin
            step(logic'((8'hB2 >> (7 - i)) & 8'h01), 1'b1, 1'b1, 1'b0, 1'b0);
            chk("single_pre_valid", 32'(wif.word_valid), 32'd0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("single_valid", 32'(wif.word_valid), 32'd1);
        chk("single_word",  32'(wif.word),       32'hB2);
        chk("single_ones",  32'(wif.ones),       32'd4);
        idle(1'b1);
        chk("single_valid_fall", 32'(wif.word_valid), 32'd0);

        // Gapped sampling and back-to-back transfer
        do_reset();
        seen_w.delete();
        seen_o.delete();
        cap_on = 1'b1;
        feed_byte_gapped(8'hFF, 1'b1);
        feed_byte_gapped(8'h00, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cap_on = 1'b0;
        chk("gap_count", 32'(seen_w.size()), 32'd2);
        if (seen_w.size() == 2) begin
            chk("gap_w0", 32'(seen_w[0]), 32'hFF);
            chk("gap_o0", 32'(seen_o[0]), 32'd8);
            chk("gap_w1", 32'(seen_w[1]), 32'h00);
            chk("gap_o1", 32'(seen_o[1]), 32'd0);
        end
        chk("gap_ovf", 32'(overflow), 32'd0);

        // Overflow: second word dropped while the first is held
        do_reset();
        feed_byte(8'h5A, 1'b0);
        for (int i = 0; i < 7; i++) step(logic'((8'hC3 >> (7 - i)) & 8'h01), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_before", 32'(overflow), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_set",   32'(overflow),   32'd1);
        chk("ovf_word",  32'(wif.word),   32'h5A);
        chk("ovf_ones",  32'(wif.ones),   32'd4);
        chk("ovf_valid", 32'(wif.word_valid), 32'd1);
        seen_w.delete();
        seen_o.delete();
        cap_on = 1'b1;
        idle(1'b1);
        chk("ovf_consumed", 32'(wif.word_valid), 32'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        cap_on = 1'b0;
        chk("ovf_no_c3", 32'(seen_w.size()), 32'd0);

        // Simultaneous take and done
        do_reset();
        feed_byte(8'h0F, 1'b0);
        for (int i = 0; i < 7; i++) step(logic'((8'hF0 >> (7 - i)) & 8'h01), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("td_hold", 32'(wif.word), 32'h0F);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("td_word",  32'(wif.word),       32'hF0);
        chk("td_valid", 32'(wif.word_valid), 32'd1);
        chk("td_ones",  32'(wif.ones),       32'd4);
        chk("td_ovf",   32'(overflow),       32'd0);
        idle(1'b1);
        chk("td_drain", 32'(wif.word_valid), 32'd0);

        // Reset mid-word, then set-beats-clear race
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        feed_byte(8'hA5, 1'b0);
        chk("rst_mid_word", 32'(wif.word), 32'hA5);
        chk("rst_mid_ones", 32'(wif.ones), 32'd4);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("race_ovf", 32'(overflow), 32'd1);
        chk("race_word", 32'(wif.word), 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Table of single words with the consumer always ready
        do_reset();
        for (int t = 0; t < 8; t++) begin
            feed_byte(tbl[t].din, 1'b1);
            chk("tbl_valid", 32'(wif.word_valid), 32'd1);
            chk("tbl_word",  32'(wif.word),       32'(tbl[t].din));
            chk("tbl_ones",  32'(wif.ones),       32'(tbl[t].exp_ones));
            idle(1'b1);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            step(logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 9) < 7),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
